// File: rtl/assert_monitor_pkg.sv
// Shared definitions for the multi-channel assertion monitor: ID width helper,
// failure message text and default counter width.
package assert_monitor_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam string       FAIL_MSG  = "ASSERTION FAILED: channel";

  // ceil(log2(n)) with a floor of 1 so a single channel still gets a 1-bit ID
  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/assert_prio_popcnt.sv
// Combinational hit-vector reduction: lowest set index, any-set flag and popcount.
module assert_prio_popcnt
  import assert_monitor_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned ID_W  = id_width(N_CH),
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [N_CH-1:0]  hit,
  output logic [ID_W-1:0]  low_id_c,
  output logic             any_c,
  output logic [CNT_W:0]   count_c
);

  always_comb begin
    low_id_c = '0;
    any_c    = |hit;
    count_c  = '0;
    // scan downwards so the lowest set index is the one left standing
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (hit[i]) low_id_c = ID_W'(i);
    end
    for (int i = 0; i < int'(N_CH); i++) begin
      count_c = count_c + (CNT_W + 1)'(hit[i]);
    end
  end

endmodule

// File: rtl/assert_monitor.sv
// Multi-channel post-reset assertion monitor: holdoff arming, sticky per-channel
// failure flags, first-fail ID, saturating failure count and a fail pulse.
module assert_monitor
  import assert_monitor_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned HOLDOFF       = 2,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter bit          STOP_ON_FAIL  = 1'b1,
  parameter bit          PRINT_ON_FAIL = 1'b1,
  parameter int unsigned ID_W          = id_width(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  io_en,
  input  logic [N_CH-1:0]  io_cond,
  input  logic             io_clear,
  output logic             io_armed,
  output logic             io_fail_pulse,
  output logic             io_fail_any,
  output logic [N_CH-1:0]  io_fail_vec,
  output logic             io_first_valid,
  output logic [ID_W-1:0]  io_first_id,
  output logic [CNT_W-1:0] io_fail_count
);

  localparam int unsigned      HO_W    = 8;
  localparam int unsigned      SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [HO_W-1:0]  holdoff_q, holdoff_d;
  logic             armed_d;
  logic [N_CH-1:0]  hit_c;
  logic             any_c;
  logic [ID_W-1:0]  low_id_c;
  logic [CNT_W:0]   pop_c;
  logic [N_CH-1:0]  base_vec, vec_d;
  logic [CNT_W-1:0] base_cnt, cnt_d;
  logic             base_valid, first_valid_d;
  logic [ID_W-1:0]  base_id, first_id_d;
  logic [SUM_W-1:0] sum_c;

  assign hit_c = {N_CH{io_armed}} & io_en & ~io_cond;

  assert_prio_popcnt #(
    .N_CH  (N_CH),
    .ID_W  (ID_W),
    .CNT_W (CNT_W)
  ) u_prio_popcnt (
    .hit      (hit_c),
    .low_id_c (low_id_c),
    .any_c    (any_c),
    .count_c  (pop_c)
  );

  // Next-state: clear wipes the accumulated status, this cycle's hits still land
  always_comb begin
    holdoff_d     = (holdoff_q == '0) ? '0 : holdoff_q - HO_W'(1);
    armed_d       = (holdoff_d == '0);
    base_vec      = io_clear ? '0 : io_fail_vec;
    base_cnt      = io_clear ? '0 : io_fail_count;
    base_valid    = io_clear ? 1'b0 : io_first_valid;
    base_id       = io_clear ? '0 : io_first_id;
    vec_d         = base_vec | hit_c;
    sum_c         = SUM_W'(base_cnt) + SUM_W'(pop_c);
    cnt_d         = (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_c[CNT_W-1:0];
    first_valid_d = base_valid;
    first_id_d    = base_id;
    if (!base_valid && any_c) begin
      first_valid_d = 1'b1;
      first_id_d    = low_id_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      holdoff_q      <= HO_W'(HOLDOFF);
      io_armed       <= 1'b0;
      io_fail_pulse  <= 1'b0;
      io_fail_any    <= 1'b0;
      io_fail_vec    <= '0;
      io_first_valid <= 1'b0;
      io_first_id    <= '0;
      io_fail_count  <= '0;
    end else begin
      holdoff_q      <= holdoff_d;
      io_armed       <= armed_d;
      io_fail_pulse  <= any_c;
      io_fail_any    <= |vec_d;
      io_fail_vec    <= vec_d;
      io_first_valid <= first_valid_d;
      io_first_id    <= first_id_d;
      io_fail_count  <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of each failing channel, optionally ending the run
  always_ff @(posedge clk) begin
    if (!reset && any_c) begin
      if (PRINT_ON_FAIL) begin
        for (int i = 0; i < int'(N_CH); i++) begin
          if (hit_c[i]) $display("%s %0d", FAIL_MSG, i);
        end
      end
      if (STOP_ON_FAIL) $finish;
    end
  end
`endif

endmodule

// File: tb/tb_assert_monitor.sv
// Directed bench for assert_monitor: holdoff, single/multi failure, disable,
// saturation, clear collision and mid-operation reset.
module tb_assert_monitor;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ID_W  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  io_en;
  logic [N_CH-1:0]  io_cond;
  logic             io_clear;
  logic             io_armed;
  logic             io_fail_pulse;
  logic             io_fail_any;
  logic [N_CH-1:0]  io_fail_vec;
  logic             io_first_valid;
  logic [ID_W-1:0]  io_first_id;
  logic [CNT_W-1:0] io_fail_count;

  int checks = 0;
  int errors = 0;

  assert_monitor #(
    .N_CH          (N_CH),
    .HOLDOFF       (2),
    .CNT_W         (CNT_W),
    .STOP_ON_FAIL  (1'b0),
    .PRINT_ON_FAIL (1'b0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .io_en          (io_en),
    .io_cond        (io_cond),
    .io_clear       (io_clear),
    .io_armed       (io_armed),
    .io_fail_pulse  (io_fail_pulse),
    .io_fail_any    (io_fail_any),
    .io_fail_vec    (io_fail_vec),
    .io_first_valid (io_first_valid),
    .io_first_id    (io_first_id),
    .io_fail_count  (io_fail_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic pulse, input logic any,
                              input logic [3:0] vec, input logic valid,
                              input logic [1:0] id, input logic [3:0] cnt);
    check({tag, ".pulse"}, 32'(io_fail_pulse), 32'(pulse));
    check({tag, ".any"},   32'(io_fail_any),   32'(any));
    check({tag, ".vec"},   32'(io_fail_vec),   32'(vec));
    check({tag, ".valid"}, 32'(io_first_valid), 32'(valid));
    check({tag, ".id"},    32'(io_first_id),   32'(id));
    check({tag, ".count"}, 32'(io_fail_count), 32'(cnt));
  endtask

  initial begin
    reset    = 1'b1;
    io_en    = 4'h0;
    io_cond  = 4'hF;
    io_clear = 1'b0;
    repeat (3) step();
    check("rst.armed", 32'(io_armed), 32'd0);
    check_status("rst", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);

    // holdoff: all channels failing from the first post-reset cycle
    reset   = 1'b0;
    io_en   = 4'hF;
    io_cond = 4'h0;
    check("ho.armed0", 32'(io_armed), 32'd0);
    step();
    check("ho.armed1", 32'(io_armed), 32'd0);
    check("ho.pulse1", 32'(io_fail_pulse), 32'd0);
    step();
    check("ho.armed2", 32'(io_armed), 32'd1);
    check_status("ho.arm", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);
    step();
    check_status("ho.first", 1'b1, 1'b1, 4'hF, 1'b1, 2'd0, 4'd4);

    // clear with no hits
    io_en    = 4'h0;
    io_cond  = 4'hF;
    io_clear = 1'b1;
    step();
    io_clear = 1'b0;
    check_status("clr", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);

    // single failure on ch2
    io_en   = 4'b0100;
    io_cond = 4'b1011;
    step();
    io_cond = 4'hF;
    check_status("ch2", 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd1);
    step();
    check_status("ch2.after", 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd1);

    // later ch0 failure keeps first ID
    io_en   = 4'b0101;
    io_cond = 4'b1110;
    step();
    io_cond = 4'hF;
    check_status("ch0", 1'b1, 1'b1, 4'b0101, 1'b1, 2'd2, 4'd2);

    // disabled channels never fail
    io_en    = 4'h0;
    io_cond  = 4'h0;
    io_clear = 1'b1;
    step();
    io_clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("dis.pulse", 32'(io_fail_pulse), 32'd0);
    end
    check_status("dis", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);

    // saturation: ch1 fails for 20 cycles
    io_en = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("sat.count", 32'(io_fail_count), (k < 15) ? 32'(k) : 32'd15);
      check("sat.pulse", 32'(io_fail_pulse), 32'd1);
    end
    check_status("sat", 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd15);

    // clear collision: build vec=0001 count=3, then clear with a ch3 hit
    io_en    = 4'h0;
    io_clear = 1'b1;
    step();
    io_clear = 1'b0;
    io_en    = 4'b0001;
    repeat (3) step();
    check_status("pre", 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 4'd3);
    io_en    = 4'b1000;
    io_clear = 1'b1;
    step();
    io_clear = 1'b0;
    io_en    = 4'h0;
    check_status("coll", 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 4'd1);

    // reset mid-operation; failures during holdoff are dropped
    reset = 1'b1;
    step();
    check("mid.armed", 32'(io_armed), 32'd0);
    check_status("mid.rst", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);
    reset   = 1'b0;
    io_en   = 4'hF;
    io_cond = 4'b1101;
    step();
    check("mid.armed1", 32'(io_armed), 32'd0);
    check_status("mid.ho1", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);
    step();
    check("mid.armed2", 32'(io_armed), 32'd1);
    check_status("mid.ho2", 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'd0);
    step();
    check_status("mid.post", 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
